// File: rtl/ad_ip_jesd204_tpl_adc_capture.sv
// Capture controller between the JESD204 TPL ADC core and the DMA.
// It gates sample beats by capture mode, runs the arm/trigger/burst sequence, and counts DMA overflows.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | not armed; beats pass only when the live mode input is 0
// ARMED   | waiting for a rising edge on sync_in or sync_manual_req
// CAPTURE | beats pass; in burst modes the valid beats are counted
// DONE    | burst complete, capture_done high; no beats pass
module ad_ip_jesd204_tpl_adc_capture #(
    parameter int NUM_CHANNELS        = 4,
    parameter int DATA_PATH_WIDTH     = 1,
    parameter int DMA_BITS_PER_SAMPLE = 16,
    parameter int CNT_WIDTH           = 16,
    parameter int OVF_CNT_WIDTH       = 8
) (
    input  logic                                                      clk,
    input  logic                                                      resetn,
    input  logic                                                      arm,
    input  logic                                                      disarm,
    input  logic [1:0]                                                mode,
    input  logic [CNT_WIDTH-1:0]                                      capture_len,
    input  logic                                                      sync_in,
    input  logic                                                      sync_manual_req,
    input  logic [NUM_CHANNELS-1:0]                                   enable,
    input  logic                                                      in_valid,
    input  logic [NUM_CHANNELS*DATA_PATH_WIDTH*DMA_BITS_PER_SAMPLE-1:0] in_data,
    output logic [NUM_CHANNELS-1:0]                                   out_valid,
    output logic [NUM_CHANNELS*DATA_PATH_WIDTH*DMA_BITS_PER_SAMPLE-1:0] out_data,
    input  logic                                                      dovf,
    output logic [1:0]                                                state,
    output logic                                                      capture_done,
    output logic                                                      ovf,
    output logic [OVF_CNT_WIDTH-1:0]                                  ovf_count
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t               st;
    logic [1:0]           mode_l;
    logic [CNT_WIDTH-1:0] len_l;
    logic [CNT_WIDTH-1:0] beat_cnt;
    logic                 sync_d;
    logic                 manual_d;
    logic                 trigger;
    logic                 arm_accept;
    logic                 gate;
    logic                 burst_mode;

    assign trigger    = (sync_in & ~sync_d) | (sync_manual_req & ~manual_d);
    assign arm_accept = arm & ~disarm & ((st == S_IDLE) | (st == S_DONE));
    // Mode 0 follows the live mode input so continuous capture needs no arm.
    assign gate       = (st == S_CAPTURE) | ((st == S_IDLE) & (mode == 2'd0));
    assign burst_mode = (mode_l == 2'd2) | (mode_l == 2'd3);

    assign state        = st;
    assign capture_done = (st == S_DONE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            st       <= S_IDLE;
            mode_l   <= 2'd0;
            len_l    <= CNT_WIDTH'(1);
            beat_cnt <= '0;
            sync_d   <= 1'b0;
            manual_d <= 1'b0;
        end else begin
            sync_d   <= sync_in;
            manual_d <= sync_manual_req;
            if (disarm) begin
                st <= S_IDLE;
            end else begin
                case (st)
                    S_IDLE, S_DONE: begin
                        if (arm) begin
                            mode_l   <= mode;
                            len_l    <= (capture_len == '0) ? CNT_WIDTH'(1) : capture_len;
                            beat_cnt <= '0;
                            case (mode)
                                2'd0:    st <= S_IDLE;
                                2'd3:    st <= S_CAPTURE;
                                default: st <= S_ARMED;
                            endcase
                        end
                    end
                    S_ARMED: begin
                        if (trigger) st <= S_CAPTURE;
                    end
                    S_CAPTURE: begin
                        if (burst_mode && in_valid) begin
                            if (beat_cnt == len_l - CNT_WIDTH'(1)) st <= S_DONE;
                            else beat_cnt <= beat_cnt + CNT_WIDTH'(1);
                        end
                    end
                    default: st <= S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid <= '0;
            out_data  <= '0;
        end else begin
            out_valid <= {NUM_CHANNELS{in_valid & gate}} & enable;
            if (in_valid) out_data <= in_data;
        end
    end

    // An accepted arm takes priority over an overflow seen in the same cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ovf       <= 1'b0;
            ovf_count <= '0;
        end else if (arm_accept) begin
            ovf       <= 1'b0;
            ovf_count <= '0;
        end else if (dovf && (|out_valid)) begin
            ovf <= 1'b1;
            if (ovf_count != '1) ovf_count <= ovf_count + OVF_CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_capture.sv
// Directed bench for the TPL ADC capture controller with default parameters (4 channels, 64-bit data).
module tb_ad_ip_jesd204_tpl_adc_capture;

    logic        clk = 1'b0;
    logic        resetn;
    logic        arm, disarm;
    logic [1:0]  mode;
    logic [15:0] capture_len;
    logic        sync_in, sync_manual_req;
    logic [3:0]  enable;
    logic        in_valid;
    logic [63:0] in_data;
    logic [3:0]  out_valid;
    logic [63:0] out_data;
    logic        dovf;
    logic [1:0]  state;
    logic        capture_done;
    logic        ovf;
    logic [7:0]  ovf_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ad_ip_jesd204_tpl_adc_capture dut (
        .clk(clk), .resetn(resetn), .arm(arm), .disarm(disarm), .mode(mode),
        .capture_len(capture_len), .sync_in(sync_in), .sync_manual_req(sync_manual_req),
        .enable(enable), .in_valid(in_valid), .in_data(in_data), .out_valid(out_valid),
        .out_data(out_data), .dovf(dovf), .state(state), .capture_done(capture_done),
        .ovf(ovf), .ovf_count(ovf_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; arm = 0; disarm = 0; mode = 2'd1; capture_len = 0;
        sync_in = 0; sync_manual_req = 0; enable = 4'h0; in_valid = 0; in_data = '0; dovf = 0;
        step(); step();
        total++; if (state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
        total++; if (out_valid !== 4'h0) begin bad++; $display("FAIL reset_out_valid got=%h exp=0", out_valid); end
        total++; if (out_data !== 64'h0) begin bad++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        total++; if ({capture_done, ovf, ovf_count} !== 10'h0) begin bad++; $display("FAIL reset_flags got=%b/%b/%0d exp=0/0/0", capture_done, ovf, ovf_count); end
        resetn = 1'b1;
        step();
    endtask

    task automatic test_mode0();
        int errs = 0;
        mode = 2'd0; enable = 4'b0101;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1; in_data = 64'h1111_2222_3333_4444 * 64'(i + 1);
            step();
            if (out_valid !== 4'b0101 || out_data !== 64'h1111_2222_3333_4444 * 64'(i + 1) || state !== 2'd0) errs++;
        end
        total++; if (errs != 0) begin bad++; $display("FAIL mode0_stream errors=%0d exp=0", errs); end
        in_valid = 0; in_data = 64'hDEAD_BEEF_0000_0001;
        step();
        total++; if (out_valid !== 4'h0) begin bad++; $display("FAIL mode0_idle_valid got=%h exp=0", out_valid); end
        total++; if (out_data !== 64'h1111_2222_3333_4444 * 64'd8) begin bad++; $display("FAIL mode0_hold got=%h exp=%h", out_data, 64'h1111_2222_3333_4444 * 64'd8); end
    endtask

    task automatic test_burst();
        int beats = 0;
        int bad_order = 0;
        mode = 2'd2; capture_len = 16'd5; enable = 4'hF; sync_in = 0;
        arm = 1; step(); arm = 0;
        total++; if (state !== 2'd1) begin bad++; $display("FAIL burst_armed got=%0d exp=1", state); end
        for (int i = 0; i < 6; i++) begin
            in_valid = (i % 2 == 0); in_data = 64'(i);
            step();
        end
        total++; if (out_valid !== 4'h0 || state !== 2'd1) begin bad++; $display("FAIL burst_no_pass_armed got=%h/%0d exp=0/1", out_valid, state); end
        in_valid = 0; sync_in = 1;
        step();
        total++; if (state !== 2'd2) begin bad++; $display("FAIL burst_trigger got=%0d exp=2", state); end
        for (int i = 0; i < 20; i++) begin
            in_valid = (i % 2 == 0); in_data = 64'(100 + i);
            step();
            if (out_valid === 4'hF) begin
                beats++;
                if ((beats < 5 && state !== 2'd2) || (beats == 5 && state !== 2'd3)) bad_order++;
                if (out_data !== 64'(100 + i)) bad_order++;
            end
        end
        total++; if (beats != 5) begin bad++; $display("FAIL burst_beats got=%0d exp=5", beats); end
        total++; if (bad_order != 0) begin bad++; $display("FAIL burst_sequence errors=%0d exp=0", bad_order); end
        total++; if (state !== 2'd3 || capture_done !== 1'b1) begin bad++; $display("FAIL burst_done got=%0d/%b exp=3/1", state, capture_done); end
        in_valid = 1; step(); step();
        total++; if (out_valid !== 4'h0 || capture_done !== 1'b1) begin bad++; $display("FAIL burst_done_hold got=%h/%b exp=0/1", out_valid, capture_done); end
        in_valid = 0; sync_in = 0;
    endtask

    task automatic test_stream();
        int errs = 0;
        mode = 2'd1; enable = 4'hF;
        arm = 1; step(); arm = 0;
        total++; if (state !== 2'd1) begin bad++; $display("FAIL stream_armed got=%0d exp=1", state); end
        sync_manual_req = 1; step();
        total++; if (state !== 2'd2) begin bad++; $display("FAIL stream_trigger got=%0d exp=2", state); end
        for (int i = 0; i < 10; i++) begin
            in_valid = 1; in_data = 64'(i);
            step();
            if (out_valid !== 4'hF || state !== 2'd2) errs++;
        end
        total++; if (errs != 0) begin bad++; $display("FAIL stream_run errors=%0d exp=0", errs); end
        enable = 4'b0011; step();
        total++; if (out_valid !== 4'b0011) begin bad++; $display("FAIL stream_enable got=%h exp=3", out_valid); end
        disarm = 1; step(); disarm = 0;
        total++; if (state !== 2'd0) begin bad++; $display("FAIL stream_disarm_state got=%0d exp=0", state); end
        step();
        total++; if (out_valid !== 4'h0) begin bad++; $display("FAIL stream_disarm_valid got=%h exp=0", out_valid); end
        in_valid = 0; sync_manual_req = 0; enable = 4'hF;
    endtask

    task automatic test_immediate();
        int beats = 0;
        mode = 2'd3; capture_len = 16'd0;
        arm = 1; step(); arm = 0;
        total++; if (state !== 2'd2) begin bad++; $display("FAIL imm_capture got=%0d exp=2", state); end
        for (int i = 0; i < 6; i++) begin
            in_valid = 1; step();
            if (out_valid === 4'hF) beats++;
        end
        total++; if (beats != 1 || state !== 2'd3) begin bad++; $display("FAIL imm_len0 beats=%0d state=%0d exp=1/3", beats, state); end
        in_valid = 0; capture_len = 16'd3;
        arm = 1; step(); arm = 0;
        beats = 0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1; step();
            if (out_valid === 4'hF) beats++;
        end
        total++; if (beats != 3 || state !== 2'd3) begin bad++; $display("FAIL imm_len3 beats=%0d state=%0d exp=3/3", beats, state); end
        in_valid = 0;
    endtask

    task automatic test_overflow();
        mode = 2'd2; capture_len = 16'd300; sync_in = 0; dovf = 0;
        arm = 1; step(); arm = 0;
        sync_in = 1; step();
        total++; if (state !== 2'd2) begin bad++; $display("FAIL ovf_trigger got=%0d exp=2", state); end
        in_valid = 1; dovf = 1;
        for (int i = 0; i < 10; i++) step();
        total++; if (ovf_count !== 8'd9 || ovf !== 1'b1) begin bad++; $display("FAIL ovf_partial got=%0d/%b exp=9/1", ovf_count, ovf); end
        for (int i = 0; i < 300; i++) step();
        total++; if (ovf_count !== 8'd255 || ovf !== 1'b1 || state !== 2'd3) begin bad++; $display("FAIL ovf_saturate got=%0d/%b/%0d exp=255/1/3", ovf_count, ovf, state); end
        in_valid = 0; dovf = 0; capture_len = 16'd8;
        arm = 1; step(); arm = 0;
        total++; if (ovf_count !== 8'd0 || ovf !== 1'b0 || state !== 2'd1) begin bad++; $display("FAIL ovf_clear got=%0d/%b/%0d exp=0/0/1", ovf_count, ovf, state); end
        sync_in = 0;
    endtask

    task automatic test_arm_disarm();
        disarm = 1; step(); disarm = 0;
        total++; if (state !== 2'd0) begin bad++; $display("FAIL ad_prep got=%0d exp=0", state); end
        mode = 2'd2; capture_len = 16'd8;
        arm = 1; disarm = 1; step(); arm = 0; disarm = 0;
        step();
        total++; if (state !== 2'd0) begin bad++; $display("FAIL arm_disarm_same got=%0d exp=0", state); end
        sync_in = 1; step(); step();
        total++; if (state !== 2'd0) begin bad++; $display("FAIL idle_trigger got=%0d exp=0", state); end
    endtask

    task automatic test_reset_mid();
        int errs = 0;
        mode = 2'd2; capture_len = 16'd8; sync_in = 1;
        arm = 1; step(); arm = 0;
        step(); step();
        total++; if (state !== 2'd1) begin bad++; $display("FAIL held_sync got=%0d exp=1", state); end
        sync_in = 0; step();
        sync_in = 1; step();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; in_data = 64'hA5A5_0000_0000_0000 + 64'(i); step();
            if (out_valid !== 4'hF) errs++;
        end
        total++; if (errs != 0 || state !== 2'd2) begin bad++; $display("FAIL mid_capture errors=%0d state=%0d exp=0/2", errs, state); end
        resetn = 0; #2;
        total++; if (state !== 2'd0 || out_valid !== 4'h0 || out_data !== 64'h0 || capture_done !== 1'b0) begin bad++; $display("FAIL async_reset got=%0d/%h/%h/%b exp=0/0/0/0", state, out_valid, out_data, capture_done); end
        step(); resetn = 1;
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1; step();
            if (capture_done !== 1'b0 || state !== 2'd0 || out_valid !== 4'h0) errs++;
        end
        total++; if (errs != 0) begin bad++; $display("FAIL after_reset errors=%0d exp=0", errs); end
        in_valid = 0;
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_burst();
        test_stream();
        test_immediate();
        test_overflow();
        test_arm_disarm();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
